// File: rtl/matrix_pkg.sv
// Shared geometry, scan state encoding and row-slice helper for the 5x7 matrix column scanner.
package matrix_pkg;

    localparam int unsigned COLUNE_SIZE   = 7;
    localparam int unsigned TOTAL_COLUNES = 5;
    localparam int unsigned DATA_WIDTH    = COLUNE_SIZE * TOTAL_COLUNES;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StBlank
    } scan_state_e;

    // Active-low row bits of one column out of the packed pixel map.
    function automatic logic [COLUNE_SIZE-1:0] column_rows(input logic [DATA_WIDTH-1:0] map,
                                                           input logic [2:0] idx);
        return map[int'(idx) * COLUNE_SIZE +: COLUNE_SIZE];
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Column slot timer: counts 0..SCAN_DIV-1 and flags the last cycle of each slot.
module scan_prescaler #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic slotDone
);

    localparam int unsigned CntWidth = $clog2(SCAN_DIV);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(SCAN_DIV - 1);

    logic [CntWidth-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_cnt <= '0;
        end else if (div_cnt == CntLast) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign slotDone = !clear && (div_cnt == CntLast);

endmodule

// File: rtl/matrix_column_scanner.sv
// Multiplexes a 35-bit active-low pixel map onto a 5x7 LED matrix, one column at a time.
// Define GHOST_BLANK_EN to insert BLANK_CYCLES dark cycles between column slots.
module matrix_column_scanner
    import matrix_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DATA_WIDTH-1:0]    mapIn,
    output logic [TOTAL_COLUNES-1:0] columnOut,
    output logic [COLUNE_SIZE-1:0]   rowOut,
    output logic                     frameTick
);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("SCAN_DIV must be at least 2");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("BLANK_CYCLES must be at least 1");
    end

    localparam logic [TOTAL_COLUNES-1:0] ColA    = TOTAL_COLUNES'(1);
    localparam logic [2:0]               ColLast = 3'(TOTAL_COLUNES - 1);
    localparam logic [COLUNE_SIZE-1:0]   RowDark = '1;

    scan_state_e           state;
    logic [2:0]            col_idx;
    logic [2:0]            col_next;
    logic                  col_last;
    logic [DATA_WIDTH-1:0] frame_buf;
    logic                  clear;
    logic                  slot_done;

`ifdef GHOST_BLANK_EN
    localparam int unsigned BlankWidth = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BlankWidth-1:0] BlankLast = BlankWidth'(BLANK_CYCLES - 1);
    logic [BlankWidth-1:0] blank_cnt;
`endif

    assign col_last = (col_idx == ColLast);
    assign col_next = col_last ? 3'd0 : col_idx + 3'd1;
    // The slot timer only runs while a column is actually lit.
    assign clear    = !enable || (state != StScan);

    scan_prescaler #(
        .SCAN_DIV(SCAN_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .slotDone(slot_done)
    );

    always_ff @(posedge clk) begin
        frameTick <= 1'b0;
        if (reset) begin
            state     <= StIdle;
            col_idx   <= 3'd0;
            frame_buf <= '1;
            columnOut <= '0;
            rowOut    <= RowDark;
            frameTick <= 1'b0;
`ifdef GHOST_BLANK_EN
            blank_cnt <= '0;
`endif
        end else if (!enable) begin
            state     <= StIdle;
            col_idx   <= 3'd0;
            columnOut <= '0;
            rowOut    <= RowDark;
`ifdef GHOST_BLANK_EN
            blank_cnt <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    state     <= StScan;
                    col_idx   <= 3'd0;
                    frame_buf <= mapIn;
                    columnOut <= ColA;
                    rowOut    <= mapIn[COLUNE_SIZE-1:0];
                end
                StScan: begin
                    if (slot_done) begin
                        col_idx <= col_next;
                        // Frame boundary: fresh snapshot so mid-frame map changes never tear.
                        if (col_last) begin
                            frameTick <= 1'b1;
                            frame_buf <= mapIn;
                        end
`ifdef GHOST_BLANK_EN
                        state     <= StBlank;
                        blank_cnt <= '0;
                        columnOut <= '0;
                        rowOut    <= RowDark;
`else
                        columnOut <= ColA << col_next;
                        rowOut    <= col_last ? mapIn[COLUNE_SIZE-1:0]
                                              : column_rows(frame_buf, col_next);
`endif
                    end
                end
`ifdef GHOST_BLANK_EN
                StBlank: begin
                    if (blank_cnt == BlankLast) begin
                        state     <= StScan;
                        columnOut <= ColA << col_idx;
                        rowOut    <= column_rows(frame_buf, col_idx);
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state     <= StIdle;
                    columnOut <= '0;
                    rowOut    <= RowDark;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Directed scoreboard bench for matrix_column_scanner (SCAN_DIV=4, BLANK_CYCLES=2).
// Honours GHOST_BLANK_EN the same way the design does.
module tb_matrix_column_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYCLES = 2;
`ifdef GHOST_BLANK_EN
    localparam int SLOT   = SCAN_DIV + BLANK_CYCLES;
    localparam int TICK_T = 4 * SLOT + SCAN_DIV;
`else
    localparam int SLOT   = SCAN_DIV;
    localparam int TICK_T = 0;
`endif
    localparam int PERIOD = 5 * SLOT;

    typedef struct packed {
        logic [4:0] col;
        logic [6:0] row;
        logic       tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [34:0] mapIn;
    logic [4:0]  columnOut;
    logic [6:0]  rowOut;
    logic        frameTick;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    // Reference model: position within the frame plus the snapshot in use.
    bit          m_run  = 1'b0;
    int          m_t    = 0;
    logic [34:0] m_snap = '1;

    matrix_column_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mapIn    (mapIn),
        .columnOut(columnOut),
        .rowOut   (rowOut),
        .frameTick(frameTick)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        exp_t e;
        int   c;
        e.tick = 1'b0;
        if (reset) begin
            m_run  = 1'b0;
            m_snap = '1;
        end else if (!enable) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run  = 1'b1;
            m_t    = 0;
            m_snap = mapIn;
        end else begin
            m_t = (m_t + 1) % PERIOD;
            if (m_t == TICK_T) begin
                e.tick = 1'b1;
                m_snap = mapIn;
            end
        end
        if (!m_run || (m_t % SLOT) >= SCAN_DIV) begin
            e.col = 5'd0;
            e.row = 7'h7F;
        end else begin
            c     = m_t / SLOT;
            e.col = 5'd1 << c;
            e.row = m_snap[c*7 +: 7];
        end
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        checks++;
        assert (columnOut === e.col) else begin
            errors++;
            $error("FAIL columnOut: observed %h expected %h (t=%0d)", columnOut, e.col, m_t);
        end
        checks++;
        assert (rowOut === e.row) else begin
            errors++;
            $error("FAIL rowOut: observed %h expected %h (t=%0d)", rowOut, e.row, m_t);
        end
        checks++;
        assert (frameTick === e.tick) else begin
            errors++;
            $error("FAIL frameTick: observed %b expected %b (t=%0d)", frameTick, e.tick, m_t);
        end
        checks++;
        assert ($onehot0(columnOut)) else begin
            errors++;
            $error("FAIL onehot: observed %b expected at most one bit set", columnOut);
        end
        checks++;
        assert (columnOut != 5'd0 || rowOut == 7'h7F) else begin
            errors++;
            $error("FAIL dark_rows: observed %h expected 7f with no column", rowOut);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_out();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance to a frame position (bounded), then confirm the DUT shows that column.
    task automatic run_until(input int target, input string tag);
        int n;
        logic [4:0] want;
        n = 0;
        while (!(m_run && m_t == target) && n < 4 * PERIOD) begin
            cycle();
            n++;
        end
        want = 5'd1 << (target / SLOT);
        checks++;
        assert (columnOut === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, columnOut, want);
        end
    endtask

    initial begin
        logic [63:0] r;
        reset  = 1'b1;
        enable = 1'b0;
        mapIn  = '0;

        // Reset held for two cycles with enable low.
        run(2);
        reset = 1'b0;
        run(2);

        // Only a1 lit.
        mapIn  = 35'h7FFFFFFFE;
        enable = 1'b1;
        run(2 * PERIOD + 2);

        // Map change mid-frame while column c is lit.
        run_until(2 * SLOT + 1, "reach_col_c");
        mapIn = '0;
        run(2 * PERIOD);

        // One-cycle enable drop during column d, then restart.
        mapIn = 35'h5A5A5A5A5;
        run_until(3 * SLOT + 1, "reach_col_d");
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        run(PERIOD + 5);

        // Reset during column e.
        run_until(4 * SLOT + 1, "reach_col_e");
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run(3);

        // Random maps changed at odd intervals.
        for (int k = 0; k < 12; k++) begin
            r     = {$urandom(), $urandom()};
            mapIn = r[34:0];
            run(7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
